// File: rtl/stream_check_pkg.sv
// Shared types and constants for the LFSR stream checker: FSM states,
// Galois tap masks per data width and the ready-stall generator setup.
package stream_check_pkg;

    typedef enum logic {
        ST_RESYNC = 1'b0,
        ST_CHECK  = 1'b1
    } state_e;

    localparam int unsigned StallWidth = 8;
    // x^8 + x^6 + x^5 + x^4 + 1 in right-shift Galois form
    localparam logic [StallWidth-1:0] StallMask = 8'hB8;
    localparam logic [StallWidth-1:0] StallSeed = 8'hA5;

    localparam logic [63:0] TapMask8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] TapMask16 = 64'h0000_0000_0000_B400;
    localparam logic [63:0] TapMask24 = 64'h0000_0000_00E1_0000;
    localparam logic [63:0] TapMask32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] TapMask48 = 64'h0000_C000_0018_0000;
    localparam logic [63:0] TapMask64 = 64'hD800_0000_0000_0000;

    // Other widths fall back to the 32-bit mask, truncated by the caller.
    function automatic logic [63:0] tap_mask(input int unsigned width);
        case (width)
            8:       return TapMask8;
            16:      return TapMask16;
            24:      return TapMask24;
            32:      return TapMask32;
            48:      return TapMask48;
            64:      return TapMask64;
            default: return TapMask32;
        endcase
    endfunction

endpackage

// File: rtl/galois_lfsr_step.sv
// One right-shift Galois LFSR step: next = (state >> 1) ^ (state[0] ? Mask : 0).
module galois_lfsr_step #(
    parameter int unsigned         Width = 8,
    parameter logic [Width-1:0]    Mask  = '0
) (
    input  logic [Width-1:0] state_i,
    output logic [Width-1:0] next_c_o
);

    assign next_c_o = (state_i >> 1) ^ (state_i[0] ? Mask : '0);

endmodule

// File: rtl/stream_lfsr_checker.sv
// Checks a valid/ready stream against a Galois LFSR sequence, resyncs on the
// seed word after a clear, and keeps saturating match/mismatch/stale counts.
module stream_lfsr_checker
    import stream_check_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter logic [63:0] Seed      = 64'h0000_0000_0000_0001,
    parameter int unsigned MaxStale  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 stall_en_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [31:0]          num_received_o,
    output logic [15:0]          num_failed_o,
    output logic [15:0]          num_stale_o,
    output logic                 error_o
);

    localparam int unsigned          StaleW      = $clog2(MaxStale + 1);
    localparam logic [63:0]          TapMaskFull = tap_mask(DataWidth);
    localparam logic [DataWidth-1:0] TapMask     = TapMaskFull[DataWidth-1:0];
    localparam logic [DataWidth-1:0] SeedW       = Seed[DataWidth-1:0];

    state_e                 state_q, state_d;
    logic [DataWidth-1:0]   exp_q, exp_d;
    logic [DataWidth-1:0]   exp_next, seed_next;
    logic [StaleW-1:0]      stale_cnt_q, stale_cnt_d, stale_cnt_inc;
    logic [StallWidth-1:0]  stall_q, stall_next;
    logic [31:0]            rcv_q, rcv_d;
    logic [15:0]            fail_q, fail_d;
    logic [15:0]            stale_num_q, stale_num_d;
    logic                   err_q, err_d;
    logic                   stall_c;
    logic                   handshake_c;

    galois_lfsr_step #(.Width(DataWidth), .Mask(TapMask)) u_exp_step (
        .state_i  (exp_q),
        .next_c_o (exp_next)
    );

    galois_lfsr_step #(.Width(DataWidth), .Mask(TapMask)) u_seed_step (
        .state_i  (SeedW),
        .next_c_o (seed_next)
    );

    galois_lfsr_step #(.Width(StallWidth), .Mask(StallMask)) u_stall_step (
        .state_i  (stall_q),
        .next_c_o (stall_next)
    );

    // Ready drops on roughly one cycle in four while stalls are enabled.
    assign stall_c       = stall_en_i && (stall_q[1:0] == 2'b00);
    assign ready_o       = en_i && !stall_c;
    assign handshake_c   = valid_i && ready_o;
    assign stale_cnt_inc = stale_cnt_q + StaleW'(1);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        stale_cnt_d = stale_cnt_q;
        rcv_d       = rcv_q;
        fail_d      = fail_q;
        stale_num_d = stale_num_q;
        err_d       = err_q;

        if (clear_i) begin
            state_d     = ST_RESYNC;
            exp_d       = SeedW;
            stale_cnt_d = '0;
        end else if (handshake_c) begin
            case (state_q)
                ST_CHECK: begin
                    if (data_i == exp_q) begin
                        rcv_d = (rcv_q == '1) ? rcv_q : rcv_q + 32'd1;
                    end else begin
                        fail_d = (fail_q == '1) ? fail_q : fail_q + 16'd1;
                        err_d  = 1'b1;
                    end
                    exp_d = exp_next;
                end
                ST_RESYNC: begin
                    if (data_i == SeedW) begin
                        rcv_d       = (rcv_q == '1) ? rcv_q : rcv_q + 32'd1;
                        exp_d       = seed_next;
                        state_d     = ST_CHECK;
                        stale_cnt_d = '0;
                    end else begin
                        stale_num_d = (stale_num_q == '1) ? stale_num_q : stale_num_q + 16'd1;
                        stale_cnt_d = stale_cnt_inc;
                        // Give up waiting for the seed and start checking blind.
                        if (32'(stale_cnt_inc) >= MaxStale) begin
                            err_d       = 1'b1;
                            state_d     = ST_CHECK;
                            exp_d       = SeedW;
                            stale_cnt_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_CHECK;
            exp_q       <= SeedW;
            stale_cnt_q <= '0;
            stall_q     <= StallSeed;
            rcv_q       <= '0;
            fail_q      <= '0;
            stale_num_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            stale_cnt_q <= stale_cnt_d;
            stall_q     <= stall_next;
            rcv_q       <= rcv_d;
            fail_q      <= fail_d;
            stale_num_q <= stale_num_d;
            err_q       <= err_d;
        end
    end

    assign num_received_o = rcv_q;
    assign num_failed_o   = fail_q;
    assign num_stale_o    = stale_num_q;
    assign error_o        = err_q;

endmodule

// File: tb/tb_stream_lfsr_checker.sv
// Randomized self-checking bench for stream_lfsr_checker against a
// behavioural model of the expected-word sequence, resync and stall rules.
module tb_stream_lfsr_checker;

    localparam int unsigned DW    = 32;
    localparam logic [31:0] SEED  = 32'h0000_0001;
    localparam int          MAXST = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        en = 1'b0;
    logic        stall_en = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    logic        ready;
    logic [31:0] nrcv;
    logic [15:0] nfail;
    logic [15:0] nstale;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    bit          m_resync;
    logic [31:0] m_exp;
    int          m_stale_run;
    logic [31:0] m_rcv;
    logic [15:0] m_fail;
    logic [15:0] m_stale;
    bit          m_err;
    int          cyc_idx;

    stream_lfsr_checker #(
        .DataWidth (DW),
        .Seed      (64'h0000_0000_0000_0001),
        .MaxStale  (MAXST)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .en_i           (en),
        .stall_en_i     (stall_en),
        .data_i         (data),
        .valid_i        (valid),
        .ready_o        (ready),
        .num_received_o (nrcv),
        .num_failed_o   (nfail),
        .num_stale_o    (nstale),
        .error_o        (err)
    );

    always #5 clk = ~clk;

    // Clock cycles since reset release; indexes the stall sequence.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_idx <= 0;
        else        cyc_idx <= cyc_idx + 1;
    end

    function automatic logic [31:0] next_word(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [7:0] stall_at(input int n);
        logic [7:0] x = 8'hA5;
        for (int i = 0; i < n; i++) x = (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
        return x;
    endfunction

    function automatic bit model_ready();
        logic [7:0] s = stall_at(cyc_idx);
        return en && !(stall_en && (s[1:0] == 2'b00));
    endfunction

    task automatic model_reset();
        m_resync = 0; m_exp = SEED; m_stale_run = 0;
        m_rcv = '0; m_fail = '0; m_stale = '0; m_err = 0;
    endtask

    task automatic model_clear();
        m_resync = 1; m_exp = SEED; m_stale_run = 0;
    endtask

    task automatic model_accept(input logic [31:0] d);
        if (m_resync) begin
            if (d == SEED) begin
                if (m_rcv != '1) m_rcv++;
                m_exp = next_word(SEED); m_resync = 0; m_stale_run = 0;
            end else begin
                if (m_stale != '1) m_stale++;
                m_stale_run++;
                if (m_stale_run >= MAXST) begin
                    m_err = 1; m_resync = 0; m_exp = SEED; m_stale_run = 0;
                end
            end
        end else begin
            if (d == m_exp) begin
                if (m_rcv != '1) m_rcv++;
            end else begin
                if (m_fail != '1) m_fail++;
                m_err = 1;
            end
            m_exp = next_word(m_exp);
        end
    endtask

    task automatic send(input logic [31:0] d);
        bit done = 0;
        en = 1; valid = 1; data = d;
        for (int i = 0; i < 64 && !done; i++) begin
            #1;
            if (model_ready()) begin model_accept(d); done = 1; end
            @(posedge clk); #1;
        end
        valid = 0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: word %08h never accepted", d);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; model_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic do_clear();
        en = 1; valid = 1; data = SEED; clear = 1;
        #1; @(posedge clk); #1;
        clear = 0; valid = 0;
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (nrcv !== 32'd0)  begin miscompares++; $display("FAIL reset_rcv: got %0d want 0", nrcv); end
        vectors++; if (nfail !== 16'd0) begin miscompares++; $display("FAIL reset_fail: got %0d want 0", nfail); end
        vectors++; if (nstale !== 16'd0) begin miscompares++; $display("FAIL reset_stale: got %0d want 0", nstale); end
        vectors++; if (err !== 1'b0)    begin miscompares++; $display("FAIL reset_err: got %0b want 0", err); end
        vectors++; if (ready !== 1'b0)  begin miscompares++; $display("FAIL reset_ready: got %0b want 0", ready); end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_reset();
        send(32'h0000_0001); send(32'h8020_0003); send(32'hC030_0002); send(32'h6018_0001);
        vectors++; if (nrcv !== m_rcv)   begin miscompares++; $display("FAIL basic_rcv: got %0d want %0d", nrcv, m_rcv); end
        vectors++; if (nfail !== m_fail) begin miscompares++; $display("FAIL basic_fail: got %0d want %0d", nfail, m_fail); end
        vectors++; if (err !== m_err)    begin miscompares++; $display("FAIL basic_err: got %0b want %0b", err, m_err); end
    endtask

    task automatic test_mismatch();
        do_reset();
        send(32'h0000_0001); send(32'h8020_0003); send(32'hDEAD_BEEF); send(32'h6018_0001);
        vectors++; if (nfail !== m_fail) begin miscompares++; $display("FAIL mism_fail: got %0d want %0d", nfail, m_fail); end
        vectors++; if (nrcv !== m_rcv)   begin miscompares++; $display("FAIL mism_rcv: got %0d want %0d", nrcv, m_rcv); end
        vectors++; if (err !== m_err)    begin miscompares++; $display("FAIL mism_err: got %0b want %0b", err, m_err); end
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (err !== m_err)    begin miscompares++; $display("FAIL mism_sticky: got %0b want %0b", err, m_err); end
    endtask

    task automatic test_resync();
        do_reset();
        send(32'h0000_0001); send(32'h8020_0003); send(32'hC030_0002);
        do_clear();
        send(32'h8020_0003); send(32'hC030_0002); send(32'h0000_0001); send(32'h8020_0003);
        vectors++; if (nstale !== m_stale) begin miscompares++; $display("FAIL resync_stale: got %0d want %0d", nstale, m_stale); end
        vectors++; if (nrcv !== m_rcv)     begin miscompares++; $display("FAIL resync_rcv: got %0d want %0d", nrcv, m_rcv); end
        send(32'hC030_0002);
        vectors++; if (nrcv !== m_rcv)     begin miscompares++; $display("FAIL resync_check: got %0d want %0d", nrcv, m_rcv); end
        vectors++; if (nstale !== m_stale) begin miscompares++; $display("FAIL resync_stale2: got %0d want %0d", nstale, m_stale); end
    endtask

    task automatic test_stale_overflow();
        logic [31:0] w;
        do_reset();
        do_clear();
        for (int k = 1; k <= 5; k++) begin
            w = $urandom;
            if (w == SEED) w = 32'h2;
            send(w);
            vectors++; if (err !== m_err)      begin miscompares++; $display("FAIL stale_err[%0d]: got %0b want %0b", k, err, m_err); end
            vectors++; if (nstale !== m_stale) begin miscompares++; $display("FAIL stale_cnt[%0d]: got %0d want %0d", k, nstale, m_stale); end
            vectors++; if (nfail !== m_fail)   begin miscompares++; $display("FAIL stale_fail[%0d]: got %0d want %0d", k, nfail, m_fail); end
        end
    endtask

    task automatic test_stall();
        bit er;
        int hs = 0;
        do_reset();
        stall_en = 1; en = 1; valid = 1; data = m_exp;
        for (int c = 0; c < 256; c++) begin
            #1;
            er = model_ready();
            vectors++; if (ready !== er) begin miscompares++; $display("FAIL stall_ready[%0d]: got %0b want %0b", c, ready, er); end
            if (er) begin model_accept(data); hs++; end
            @(posedge clk); #1;
            data = m_exp;
        end
        valid = 0; stall_en = 0;
        vectors++; if (nrcv !== 32'(hs)) begin miscompares++; $display("FAIL stall_count: got %0d want %0d", nrcv, hs); end
        vectors++; if (nfail !== m_fail) begin miscompares++; $display("FAIL stall_fail: got %0d want %0d", nfail, m_fail); end
    endtask

    task automatic test_random();
        bit er;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            en       = ($urandom_range(0, 9) != 0);
            stall_en = $urandom_range(0, 1);
            valid    = ($urandom_range(0, 9) < 7);
            clear    = ($urandom_range(0, 31) == 0);
            data     = ($urandom_range(0, 3) == 0) ? $urandom : (m_resync ? SEED : m_exp);
            #1;
            er = model_ready();
            vectors++; if (ready !== er) begin miscompares++; $display("FAIL rand_ready[%0d]: got %0b want %0b", c, ready, er); end
            if (clear) model_clear();
            else if (valid && er) model_accept(data);
            @(posedge clk); #1;
            vectors++; if (nrcv !== m_rcv)     begin miscompares++; $display("FAIL rand_rcv[%0d]: got %0d want %0d", c, nrcv, m_rcv); end
            vectors++; if (nfail !== m_fail)   begin miscompares++; $display("FAIL rand_fail[%0d]: got %0d want %0d", c, nfail, m_fail); end
            vectors++; if (nstale !== m_stale) begin miscompares++; $display("FAIL rand_stale[%0d]: got %0d want %0d", c, nstale, m_stale); end
            vectors++; if (err !== m_err)      begin miscompares++; $display("FAIL rand_err[%0d]: got %0b want %0b", c, err, m_err); end
        end
        clear = 0; valid = 0; stall_en = 0; en = 1;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        send(32'h0000_0001); send(32'h1234_5678); send(32'hC030_0002);
        en = 1; valid = 1; data = m_exp;
        #2;
        rst_n = 0; model_reset();
        #1;
        vectors++; if (nrcv !== 32'd0)   begin miscompares++; $display("FAIL midrst_rcv: got %0d want 0", nrcv); end
        vectors++; if (nfail !== 16'd0)  begin miscompares++; $display("FAIL midrst_fail: got %0d want 0", nfail); end
        vectors++; if (nstale !== 16'd0) begin miscompares++; $display("FAIL midrst_stale: got %0d want 0", nstale); end
        vectors++; if (err !== 1'b0)     begin miscompares++; $display("FAIL midrst_err: got %0b want 0", err); end
        @(posedge clk); #1;
        rst_n = 1;
        send(SEED);
        vectors++; if (nrcv !== m_rcv)   begin miscompares++; $display("FAIL midrst_match: got %0d want %0d", nrcv, m_rcv); end
        vectors++; if (nfail !== m_fail) begin miscompares++; $display("FAIL midrst_nofail: got %0d want %0d", nfail, m_fail); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_mismatch();
        test_resync();
        test_stale_overflow();
        test_stall();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_lfsr_checker.md
STREAM_LFSR_CHECKER -- requirements
Module: stream_lfsr_checker

Interface
REQ-001 SHALL have parameter DataWidth, default 32, width of checked data (8..64).
REQ-002 SHALL have parameter Seed, default 32'h0000_0001, first expected word after reset/clear; nonzero.
REQ-003 SHALL have parameter MaxStale, default 16, stale words tolerated per resync.
REQ-004 SHALL have port clk_i  input  1  clock.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port clear_i  input  1  synchronous clear, restarts expected sequence.
REQ-007 SHALL have port en_i  input  1  enables acceptance.
REQ-008 SHALL have port stall_en_i  input  1  enables pseudo-random ready stalls.
REQ-009 SHALL have port data_i  input  DataWidth  stream data.
REQ-010 SHALL have port valid_i  input  1  stream valid.
REQ-011 SHALL have port ready_o  output  1  stream ready.
REQ-012 SHALL have port num_received_o  output  32  matching words, saturating.
REQ-013 SHALL have port num_failed_o  output  16  mismatches, saturating.
REQ-014 SHALL have port num_stale_o  output  16  discarded stale words, saturating.
REQ-015 SHALL have port error_o  output  1  sticky: any mismatch or stale overflow.

Function
REQ-016 SHALL accept a word only on a cycle with valid_i && ready_o (handshake); no other cycle changes counters or expected value.
REQ-017 SHALL keep expected word exp_q, advanced per checked handshake by Galois step: exp = (exp >> 1) ^ (exp[0] ? TapMask : 0), TapMask from package (32-bit: 32'h8020_0003), truncated to DataWidth.
REQ-018 SHALL implement states RESYNC, CHECK, with IDLE overlay when en_i=0 (state held, ready_o=0).
REQ-019 SHALL, in CHECK, on handshake: data_i==exp_q -> num_received+1; else num_failed+1, error_o=1; exp_q advances in both cases.
REQ-020 SHALL, in RESYNC, on handshake: data_i==Seed -> num_received+1, exp_q=step(Seed), go CHECK; else num_stale+1, stale_cnt+1, exp_q held.
REQ-021 SHALL, in RESYNC, when stale_cnt reaches MaxStale, set error_o and go CHECK with exp_q=Seed.
REQ-022 SHALL drive ready_o = en_i && !(stall_en_i && stall_q[1:0]==2'b00); stall_q is 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advancing every cycle.
REQ-023 SHALL, on clear_i, next cycle: state RESYNC, exp_q=Seed, stale_cnt=0; counters and error_o retained; handshake in the clear cycle ignored.
REQ-024 SHALL saturate every counter at all-ones, no wrap.
REQ-025 SHALL have zero-cycle combinational ready_o, one-cycle counter update latency after handshake.

Reset
REQ-026 SHALL, on rst_ni low, asynchronously set state=CHECK, exp_q=Seed, stale_cnt=0, stall_q=8'hA5, all counters 0, error_o=0.
REQ-027 SHALL, on reset mid-transfer, drop the in-flight word without counting it.

Structure
REQ-028 SHALL place TapMask constants per width and state enum in package stream_check_pkg.
REQ-029 SHALL use one sub-module galois_lfsr_step (combinational next-value, parameterized width and mask) for exp_q and stall_q.

Verification
REQ-030 Seed=1, stall off, send 1, 80200003, C0300002, 60180001 -> num_received_o=4, num_failed_o=0, error_o=0.
REQ-031 Send 1, 80200003, DEADBEEF, 60180001 -> num_failed_o=1, num_received_o=3, error_o=1 sticky.
REQ-032 Three words checked, clear_i pulse, send 80200003, C0300002, 1, 80200003 -> num_stale_o=2, num_received_o=5, state CHECK.
REQ-033 MaxStale=4, clear, send 5 non-Seed words -> error_o=1 after 4th, 5th counted as mismatch.
REQ-034 stall_en_i=1, valid_i held 256 cycles -> ready_o low exactly on stall_q[1:0]==0 cycles, no word lost or duplicated.
REQ-035 rst_ni pulsed mid-stream with valid_i high -> all outputs 0 same cycle, next word 1 counts as match.
